// File: rtl/reset_ordered_set_tx.sv
// Hard Reset / Cable Reset transmitter: serialises preamble plus the 4-symbol
// reset ordered set toward the BMC encoder and strobes the ALERT set bits.
module reset_ordered_set_tx #(
    parameter int BIT_DIV       = 4,
    parameter int PREAMBLE_BITS = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  TRANSMIT,
    input  logic        TRANSMIT_WR,
    input  logic        PHY_Stop_Attempting_Reset,
    output logic        tx_en,
    output logic        tx_bit,
    output logic        tx_busy,
    output logic [15:0] ALERT_SET,
    output logic        hardReset,
    output logic        cableReset
);

    // Bit counter must hold both the preamble index and the 20 K-code bits.
    localparam int CW = (PREAMBLE_BITS > 32) ? $clog2(PREAMBLE_BITS) : 5;
    localparam int DW = $clog2(BIT_DIV);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        KCODE    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   bit_cnt_r, bit_cnt_s;
    logic [DW-1:0]   div_cnt_r, div_cnt_s;
    logic            cable_r, cable_s;
    logic            valid_wr_s;
    logic            bit_end_s;
    logic            tx_en_s, tx_bit_s, tx_busy_s, hard_s, cable_rst_s;
    logic [15:0]     alert_s;
    logic            unused_s;

    // Symbols are packed so that pattern bit k is the k-th bit on the wire.
    function automatic logic kcode_bit(input logic is_cable, input logic [4:0] idx);
        logic [19:0] pat;
        if (is_cable) begin
            pat = {5'b00110, 5'b00111, 5'b11000, 5'b00111};
        end else begin
            pat = {5'b11001, 5'b00111, 5'b00111, 5'b00111};
        end
        return pat[idx];
    endfunction

    assign unused_s   = ^TRANSMIT[7:3];
    assign valid_wr_s = TRANSMIT_WR && ((TRANSMIT[2:0] == 3'b101) || (TRANSMIT[2:0] == 3'b110));
    assign bit_end_s  = (div_cnt_r == DW'(BIT_DIV - 1));

    // Next-state, counters and next-cycle output values.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        div_cnt_s   = div_cnt_r;
        cable_s     = cable_r;
        alert_s     = 16'h0000;
        hard_s      = 1'b0;
        cable_rst_s = 1'b0;
        tx_bit_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (valid_wr_s) begin
                    state_s   = PREAMBLE;
                    bit_cnt_s = '0;
                    div_cnt_s = '0;
                    cable_s   = (TRANSMIT[2:0] == 3'b110);
                end else begin
                    state_s = IDLE;
                end
            end
            PREAMBLE, KCODE: begin
                if (PHY_Stop_Attempting_Reset) begin
                    // Abort beats completion even on the final bit cycle.
                    state_s    = IDLE;
                    bit_cnt_s  = '0;
                    div_cnt_s  = '0;
                    alert_s[4] = 1'b1;
                end else if (!bit_end_s) begin
                    div_cnt_s = div_cnt_r + DW'(1);
                end else if (state_r == PREAMBLE && bit_cnt_r == CW'(PREAMBLE_BITS - 1)) begin
                    state_s   = KCODE;
                    bit_cnt_s = '0;
                    div_cnt_s = '0;
                end else if (state_r == KCODE && bit_cnt_r == CW'(19)) begin
                    state_s     = DONE;
                    bit_cnt_s   = '0;
                    div_cnt_s   = '0;
                    alert_s[6]  = 1'b1;
                    hard_s      = !cable_r;
                    cable_rst_s = cable_r;
                end else begin
                    bit_cnt_s = bit_cnt_r + CW'(1);
                    div_cnt_s = '0;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s   = IDLE;
                bit_cnt_s = '0;
                div_cnt_s = '0;
            end
        endcase

        if (valid_wr_s && state_r != IDLE) begin
            alert_s[5] = 1'b1;
        end else begin
            alert_s[5] = alert_s[5];
        end

        case (state_s)
            PREAMBLE: tx_bit_s = bit_cnt_s[0];
            KCODE:    tx_bit_s = kcode_bit(cable_s, bit_cnt_s[4:0]);
            default:  tx_bit_s = 1'b0;
        endcase

        tx_en_s   = (state_s == PREAMBLE) || (state_s == KCODE);
        tx_busy_s = (state_s != IDLE);
    end

    // State, counters and all outputs are registered.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= '0;
            div_cnt_r  <= '0;
            cable_r    <= 1'b0;
            tx_en      <= 1'b0;
            tx_bit     <= 1'b0;
            tx_busy    <= 1'b0;
            ALERT_SET  <= 16'h0000;
            hardReset  <= 1'b0;
            cableReset <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            div_cnt_r  <= div_cnt_s;
            cable_r    <= cable_s;
            tx_en      <= tx_en_s;
            tx_bit     <= tx_bit_s;
            tx_busy    <= tx_busy_s;
            ALERT_SET  <= alert_s;
            hardReset  <= hard_s;
            cableReset <= cable_rst_s;
        end
    end

endmodule

// File: tb/tb_reset_ordered_set_tx.sv
// Bench for reset_ordered_set_tx: scenario table with hand-derived totals, a
// cycle-level reference model checked every cycle, and a random phase.
module tb_reset_ordered_set_tx;

    localparam int D   = 4;
    localparam int P   = 64;
    localparam int LEN = (P + 20) * D;
    localparam logic [19:0] HK = 20'b11001_00111_00111_00111;
    localparam logic [19:0] CK = 20'b00110_00111_11000_00111;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  TRANSMIT = 8'h00;
    logic        TRANSMIT_WR = 1'b0;
    logic        PHY_Stop_Attempting_Reset = 1'b0;
    logic        tx_en, tx_bit, tx_busy, hardReset, cableReset;
    logic [15:0] ALERT_SET;

    int checks = 0;
    int failures = 0;

    // Reference model: transmission position in cycles since accept.
    bit   m_active = 1'b0;
    bit   m_cable = 1'b0;
    int   m_pos = 0;
    logic [20:0] m_exp = '0;

    typedef struct packed {
        logic [7:0]  tx;
        int          w2_c;
        logic [7:0]  w2_val;
        int          stop_c;
        int          en_cyc;
        logic [15:0] alert_or;
        int          alert_cnt;
        int          hard_cnt;
        int          cable_cnt;
        logic        chk_k;
        logic [19:0] kbits;
    } vec_t;

    vec_t vecs[12];

    reset_ordered_set_tx #(.BIT_DIV(D), .PREAMBLE_BITS(P)) dut (
        .CLK(CLK),
        .reset(reset),
        .TRANSMIT(TRANSMIT),
        .TRANSMIT_WR(TRANSMIT_WR),
        .PHY_Stop_Attempting_Reset(PHY_Stop_Attempting_Reset),
        .tx_en(tx_en),
        .tx_bit(tx_bit),
        .tx_busy(tx_busy),
        .ALERT_SET(ALERT_SET),
        .hardReset(hardReset),
        .cableReset(cableReset)
    );

    always #5 CLK = ~CLK;

    // k-th bit on the wire for a whole reset transmission.
    function automatic logic stream_bit(input logic cab, input int k);
        logic [4:0] code;
        int j;
        if (k < P) return k[0];
        j = k - P;
        case (j / 5)
            0:       code = 5'b00111;
            1:       code = cab ? 5'b11000 : 5'b00111;
            2:       code = 5'b00111;
            default: code = cab ? 5'b00110 : 5'b11001;
        endcase
        return code[3'(j % 5)];
    endfunction

    function automatic logic [20:0] outs();
        return {tx_en, tx_bit, tx_busy, ALERT_SET, hardReset, cableReset};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input logic wr, input logic [7:0] tx, input logic stop);
        logic valid, disc, fail;
        TRANSMIT_WR = wr;
        TRANSMIT = tx;
        PHY_Stop_Attempting_Reset = stop;
        @(posedge CLK);
        valid = wr && (tx[2:0] == 3'b101 || tx[2:0] == 3'b110);
        disc = 1'b0;
        fail = 1'b0;
        if (!reset) begin
            m_active = 1'b0;
            m_pos = 0;
        end else begin
            disc = valid && m_active;
            if (m_active && m_pos < LEN && stop) begin
                m_active = 1'b0;
                fail = 1'b1;
            end else if (m_active) begin
                m_pos++;
                if (m_pos > LEN) m_active = 1'b0;
            end else if (valid) begin
                m_active = 1'b1;
                m_pos = 0;
                m_cable = (tx[2:0] == 3'b110);
            end
        end
        m_exp = '0;
        if (m_active && m_pos < LEN) begin
            m_exp[20] = 1'b1;
            m_exp[19] = stream_bit(m_cable, m_pos / D);
        end
        m_exp[18] = m_active;
        m_exp[6] = fail;
        m_exp[7] = disc;
        if (m_active && m_pos == LEN) begin
            m_exp[8] = 1'b1;
            if (m_cable) m_exp[0] = 1'b1;
            else m_exp[1] = 1'b1;
        end
        #1;
        check("cycle_outputs", 32'(outs()), 32'(m_exp));
    endtask

    initial begin
        int ena, acnt, hc, cc;
        logic [15:0] aor;
        logic [19:0] kb;
        logic [7:0] tx_cur;
        logic [3:0] pre;
        logic wr, stp;

        vecs[0]  = '{8'h05, -1, 8'h00, -1, 336, 16'h0040, 1, 1, 0, 1'b1, HK};
        vecs[1]  = '{8'h06, -1, 8'h00, -1, 336, 16'h0040, 1, 0, 1, 1'b1, CK};
        vecs[2]  = '{8'h05, 100, 8'h06, -1, 336, 16'h0060, 2, 1, 0, 1'b1, HK};
        vecs[3]  = '{8'h05, -1, 8'h00, 281, 281, 16'h0010, 1, 0, 0, 1'b0, 20'h0};
        vecs[4]  = '{8'h03, -1, 8'h00, -1, 0, 16'h0000, 0, 0, 0, 1'b0, 20'h0};
        vecs[5]  = '{8'hFD, -1, 8'h00, -1, 336, 16'h0040, 1, 1, 0, 1'b1, HK};
        vecs[6]  = '{8'h05, -1, 8'h00, 336, 336, 16'h0010, 1, 0, 0, 1'b0, 20'h0};
        vecs[7]  = '{8'h06, -1, 8'h00, 337, 336, 16'h0040, 1, 0, 1, 1'b1, CK};
        vecs[8]  = '{8'h06, 337, 8'h05, -1, 336, 16'h0060, 2, 0, 1, 1'b1, CK};
        vecs[9]  = '{8'h05, 51, 8'h06, 51, 51, 16'h0030, 1, 0, 0, 1'b0, 20'h0};
        vecs[10] = '{8'h05, -1, 8'h00, 0, 336, 16'h0040, 1, 1, 0, 1'b1, HK};
        vecs[11] = '{8'h04, -1, 8'h00, -1, 0, 16'h0000, 0, 0, 0, 1'b0, 20'h0};

        #2 reset = 1'b0;
        #1 check("reset_state", 32'(outs()), 32'h0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h05, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            ena = 0; acnt = 0; hc = 0; cc = 0; aor = 16'h0; kb = 20'h0;
            tx_cur = vecs[i].tx;
            for (int c = 0; c < 345; c++) begin
                if (c == vecs[i].w2_c) tx_cur = vecs[i].w2_val;
                wr  = (c == 0) || (c == vecs[i].w2_c);
                stp = (c == vecs[i].stop_c);
                tick(wr, tx_cur, stp);
                ena += int'(tx_en);
                aor |= ALERT_SET;
                if (ALERT_SET != 16'h0) acnt++;
                hc += int'(hardReset);
                cc += int'(cableReset);
                if (c > P * D && c < LEN && (c - P * D) % D == 1)
                    kb[5'((c - P * D - 1) / D)] = tx_bit;
            end
            check($sformatf("v%0d_en_cycles", i), 32'(ena), 32'(vecs[i].en_cyc));
            check($sformatf("v%0d_alert_or", i), 32'(aor), 32'(vecs[i].alert_or));
            check($sformatf("v%0d_alert_cnt", i), 32'(acnt), 32'(vecs[i].alert_cnt));
            check($sformatf("v%0d_hard_cnt", i), 32'(hc), 32'(vecs[i].hard_cnt));
            check($sformatf("v%0d_cable_cnt", i), 32'(cc), 32'(vecs[i].cable_cnt));
            if (vecs[i].chk_k) check($sformatf("v%0d_kbits", i), 32'(kb), 32'(vecs[i].kbits));
        end

        // Asynchronous reset in the middle of the K-code phase.
        tick(1'b1, 8'h05, 1'b0);
        for (int c = 1; c < 300; c++) tick(1'b0, 8'h05, 1'b0);
        #2 reset = 1'b0;
        #1 check("async_reset", 32'(outs()), 32'h0);
        m_active = 1'b0;
        m_pos = 0;
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        aor = 16'h0;
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 8'h00, 1'b0);
            aor |= ALERT_SET;
        end
        check("no_strobe_after_reset", 32'(aor), 32'h0);
        pre = 4'h0;
        for (int c = 0; c < 16; c++) begin
            tick(c == 0, 8'h05, 1'b0);
            if (c % D == 0) pre[2'(c / D)] = tx_bit;
        end
        check("preamble_start", 32'(pre), 32'hA);
        for (int c = 0; c < 340; c++) tick(1'b0, 8'h05, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            tx_cur = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       tx_cur[2:0] = 3'b101;
                1:       tx_cur[2:0] = 3'b110;
                default: tx_cur[2:0] = tx_cur[2:0];
            endcase
            tick($urandom_range(0, 39) == 0, tx_cur, $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
